// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32 fetch stage: PC, 2-entry fetch queue, redirect flush
// Optional misaligned-redirect trap: define FETCH_MISALIGN_TRAP_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

    typedef enum logic {RUN, FAULT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [1:0]  count;
    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];

    logic        pop;
    logic        push;
    logic        misaligned;
    logic [31:0] target_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = |redirect_target[1:0];
    assign target_pc  = redirect_target;
`else
    assign misaligned = 1'b0;
    assign target_pc  = redirect_target & 32'hFFFF_FFFC;
`endif

    assign imem_addr    = pc;
    assign out_valid    = (state == RUN) && (count != 2'd0);
    assign pop          = out_valid && out_ready;
    assign push         = (state == RUN) && !redirect_valid && ((count != 2'd2) || pop);
    assign out_instr    = out_valid ? q_instr[0] : 32'h0;
    assign out_pc       = out_valid ? q_pc[0] : 32'h0;
    assign out_pc_plus4 = out_valid ? q_pc[0] + 32'd4 : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_PC;
            count       <= 2'd0;
            fetch_fault <= 1'b0;
            fault_pc    <= 32'h0;
            for (int i = 0; i < 2; i++) begin
                q_pc[i]    <= 32'h0;
                q_instr[i] <= 32'h0;
            end
        end else begin
            case (state)
                RUN: begin
                    if (redirect_valid) begin
                        // Redirect wins over any handshake; whatever is left is discarded.
                        count <= 2'd0;
                        if (misaligned) begin
                            state       <= FAULT;
                            fetch_fault <= 1'b1;
                            fault_pc    <= redirect_target;
                        end else begin
                            pc <= target_pc;
                        end
                    end else begin
                        if (push)
                            pc <= pc + 32'd4;
                        case ({push, pop})
                            2'b10: begin
                                q_pc[count[0]]    <= pc;
                                q_instr[count[0]] <= imem_rdata;
                                count             <= count + 2'd1;
                            end
                            2'b01: begin
                                q_pc[0]    <= q_pc[1];
                                q_instr[0] <= q_instr[1];
                                count      <= count - 2'd1;
                            end
                            2'b11: begin
                                // Count stays; the new word lands behind the surviving entry.
                                if (count == 2'd1) begin
                                    q_pc[0]    <= pc;
                                    q_instr[0] <= imem_rdata;
                                end else begin
                                    q_pc[0]    <= q_pc[1];
                                    q_instr[0] <= q_instr[1];
                                    q_pc[1]    <= pc;
                                    q_instr[1] <= imem_rdata;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                FAULT: begin
                    count <= 2'd0;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
// Honours FETCH_MISALIGN_TRAP_EN in the misaligned-redirect sequence.
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, redirect_valid, out_ready, out_valid, fetch_fault;
    logic [31:0] imem_addr, imem_rdata, redirect_target, out_instr, out_pc, out_pc_plus4, fault_pc;
    logic        rst_n2, redirect_valid2, out_ready2, out_valid2, fetch_fault2;
    logic [31:0] imem_addr2, imem_rdata2, redirect_target2, out_instr2, out_pc2, out_pc_plus42, fault_pc2;

    function automatic logic [31:0] rom(input logic [31:0] a);
        case (a)
            32'h0:   return 32'hFFC4A303;
            32'h4:   return 32'h0064A423;
            32'h8:   return 32'h0062E233;
            default: return a ^ 32'h5A5A_1234;
        endcase
    endfunction

    assign imem_rdata  = rom(imem_addr);
    assign imem_rdata2 = rom(imem_addr2);

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
        .fetch_fault(fetch_fault), .fault_pc(fault_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst_n(rst_n2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .redirect_valid(redirect_valid2), .redirect_target(redirect_target2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
        .out_pc(out_pc2), .out_pc_plus4(out_pc_plus42),
        .fetch_fault(fetch_fault2), .fault_pc(fault_pc2)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int          sel = 0;
    logic        s_valid;
    logic [31:0] s_pc, s_instr, s_p4;
    always_comb begin
        s_valid = (sel == 1) ? out_valid2    : out_valid;
        s_pc    = (sel == 1) ? out_pc2       : out_pc;
        s_instr = (sel == 1) ? out_instr2    : out_instr;
        s_p4    = (sel == 1) ? out_pc_plus42 : out_pc_plus4;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sbq[$];

    task automatic expect_pc(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = rom(pc);
        sbq.push_back(e);
    endtask

    task automatic tick(input logic rdy, input logic rv, input logic [31:0] tgt);
        @(negedge clk);
        out_ready       = rdy;
        redirect_valid  = rv;
        redirect_target = tgt;
        #2;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        rst_n2 = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Release reset, expect one empty cycle, then n back-to-back entries from the scoreboard.
    task automatic sb_stream(input int s, input int n);
        exp_t e;
        sel = s;
        @(negedge clk);
        rst_n          = 1'b1;
        rst_n2         = 1'b1;
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        #2;
        chk("release_cycle_valid", {31'b0, s_valid}, 32'd0);
        for (int i = 0; i < n; i++) begin
            if (i > 0) tick(1'b1, 1'b0, 32'h0);
            else begin
                @(negedge clk);
                #2;
            end
            chk("stream_valid", {31'b0, s_valid}, 32'd1);
            if (sbq.size() == 0) begin
                chk("scoreboard_underflow", 32'd1, 32'd0);
            end else if (s_valid) begin
                e = sbq.pop_front();
                chk("stream_pc", s_pc, e.pc);
                chk("stream_instr", s_instr, e.instr);
                chk("stream_pc_plus4", s_p4, e.pc + 32'd4);
            end
        end
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] tgt;
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] addr;
    } vec_t;
    vec_t vt[12];

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Backpressure saturation, release without bubble, then a redirect with a full queue.
        vt[0]  = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  32'h0,        32'h0};
        vt[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0,  rom(32'h0),   32'h4};
        vt[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0,  rom(32'h0),   32'h8};
        vt[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0,  rom(32'h0),   32'h8};
        vt[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0,  rom(32'h0),   32'h8};
        vt[5]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0,  rom(32'h0),   32'h8};
        vt[6]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h4,  rom(32'h4),   32'hC};
        vt[7]  = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h8,  rom(32'h8),   32'h10};
        vt[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hC,  rom(32'hC),   32'h14};
        vt[9]  = '{1'b1, 1'b1, 32'h0, 1'b1, 32'hC,  rom(32'hC),   32'h14};
        vt[10] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0,  32'h0,        32'h0};
        vt[11] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0,  32'hFFC4A303, 32'h4};

        rst_n = 1'b0; rst_n2 = 1'b0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        out_ready2 = 1'b1; redirect_valid2 = 1'b0; redirect_target2 = 32'h0;

        @(negedge clk);
        #2;
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_imem_addr", imem_addr, 32'h0);
        chk("reset_out_pc", out_pc, 32'h0);
        chk("reset_out_instr", out_instr, 32'h0);
        chk("reset_out_pc_plus4", out_pc_plus4, 32'h0);
        chk("reset_fetch_fault", {31'b0, fetch_fault}, 32'd0);
        chk("reset_fault_pc", fault_pc, 32'h0);
        chk("reset_addr_dut2", imem_addr2, 32'hFFFF_FFF8);

        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
        sb_stream(0, 3);

        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            rst_n           = 1'b1;
            rst_n2          = 1'b1;
            out_ready       = vt[i].rdy;
            redirect_valid  = vt[i].rv;
            redirect_target = vt[i].tgt;
            #2;
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, vt[i].v});
            chk($sformatf("vec%0d_pc", i), out_pc, vt[i].pc);
            chk($sformatf("vec%0d_instr", i), out_instr, vt[i].instr);
            chk($sformatf("vec%0d_addr", i), imem_addr, vt[i].addr);
        end

        do_reset();
        tick(1'b1, 1'b0, 32'h0);
        rst_n = 1'b1; rst_n2 = 1'b1;
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        chk("pre_misalign_addr", imem_addr, 32'h8);
        tick(1'b1, 1'b1, 32'h6);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int k = 0; k < 12; k++) begin
            tick(1'b1, (k == 5), 32'h0);
            chk("fault_valid_low", {31'b0, out_valid}, 32'd0);
            chk("fault_flag", {31'b0, fetch_fault}, 32'd1);
            chk("fault_pc", fault_pc, 32'h6);
            chk("fault_addr_hold", imem_addr, 32'h8);
        end
`else
        tick(1'b1, 1'b0, 32'h0);
        chk("misalign_bubble", {31'b0, out_valid}, 32'd0);
        chk("misalign_no_fault", {31'b0, fetch_fault}, 32'd0);
        tick(1'b1, 1'b0, 32'h0);
        chk("misalign_valid", {31'b0, out_valid}, 32'd1);
        chk("misalign_pc", out_pc, 32'h4);
        chk("misalign_instr", out_instr, 32'h0064A423);
        chk("misalign_fault_pc", fault_pc, 32'h0);
`endif

        do_reset();
        sbq.delete();
        expect_pc(32'h0); expect_pc(32'h4);
        sb_stream(0, 2);
        chk("pre_reset_valid", {31'b0, out_valid}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", {31'b0, out_valid}, 32'd0);
        chk("async_reset_pc", out_pc, 32'h0);
        chk("async_reset_addr", imem_addr, 32'h0);
        chk("async_reset_fault", {31'b0, fetch_fault}, 32'd0);
        sbq.delete();
        expect_pc(32'h0); expect_pc(32'h4); expect_pc(32'h8);
        sb_stream(0, 3);

        do_reset();
        sbq.delete();
        expect_pc(32'hFFFF_FFF8); expect_pc(32'hFFFF_FFFC); expect_pc(32'h0);
        sb_stream(1, 3);
        chk("wrap_fault_dut2", {31'b0, fetch_fault2} | fault_pc2, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
